dpram_arbiter: RTL and testbench

- Round-robin scheduler that shares a 16x8 true dual-port RAM between NREQ requesters.
- Each cycle it grants up to two pending requests: the first winner goes to RAM port 0, the second to port 1.
- It drives the RAM port controls and routes read data back to the requester that issued the read.
- Sits between client blocks and the dual-port RAM. The RAM here has two posedge-clocked ports with 1-cycle registered read.

---
 rtl/dpram_arbiter_pkg.sv | 16 +
 rtl/dpram_arbiter_rr_pick2.sv | 56 +++++
 rtl/dpram_arbiter.sv | 112 +++++++++++
 tb/tb_dpram_arbiter.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/dpram_arbiter_pkg.sv
// Shared definitions for the dual-port RAM round-robin arbiter.
// Holds the parameter defaults, the scan-index width and the per-port read tag.
package dpram_arbiter_pkg;

    localparam int NREQ_DEF = 4;
    localparam int AW_DEF   = 4;
    localparam int DW_DEF   = 8;
    localparam int RR_W     = $clog2(NREQ_DEF);

    // Marks which requester owns the read data returning on a RAM port.
    typedef struct packed {
        logic            valid;
        logic [RR_W-1:0] index;
    } port_tag_t;

endpackage

// File: rtl/dpram_arbiter_rr_pick2.sv
// Combinational round-robin picker: first and second requester in scan order from ptr.
// The second winner is dropped, not replaced, when it conflicts with the first.
module rr_pick2
    import dpram_arbiter_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int W    = RR_W
) (
    input  logic [NREQ-1:0]            req,
    input  logic [W-1:0]               ptr,
    input  logic [NREQ-1:0][NREQ-1:0]  conflict,
    output logic [NREQ-1:0]            w1_oh,
    output logic [NREQ-1:0]            w2_oh,
    output logic                       w1_vld,
    output logic                       w2_vld,
    output logic [W-1:0]               w1_idx,
    output logic [W-1:0]               w2_idx
);

    logic [W-1:0] idx;
    logic         found2;

    always_comb begin
        w1_vld = 1'b0;
        w1_idx = '0;
        w2_vld = 1'b0;
        w2_idx = '0;
        found2 = 1'b0;
        idx    = '0;
        w1_oh  = '0;
        w2_oh  = '0;

        for (int k = 0; k < NREQ; k++) begin
            idx = ptr + W'(k);
            if (!w1_vld && req[idx]) begin
                w1_vld = 1'b1;
                w1_idx = idx;
            end
        end

        // Indices between ptr and winner 1 are known idle, so scanning on from
        // winner 1 with wrap-around is the same as continuing the ptr scan.
        for (int k = 1; k < NREQ; k++) begin
            idx = w1_idx + W'(k);
            if (w1_vld && !found2 && req[idx]) begin
                found2 = 1'b1;
                w2_idx = idx;
            end
        end

        w2_vld         = found2 && !conflict[w1_idx][w2_idx];
        w1_oh[w1_idx]  = w1_vld;
        w2_oh[w2_idx]  = w2_vld;
    end

endmodule

// File: rtl/dpram_arbiter.sv
// Shares a true dual-port RAM between NREQ requesters, granting up to two per cycle
// and steering each port's registered read data back to the requester that issued it.
module dpram_arbiter
    import dpram_arbiter_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int AW   = AW_DEF,
    parameter int DW   = DW_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ-1:0]     we,
    input  logic [NREQ*AW-1:0]  addr,
    input  logic [NREQ*DW-1:0]  wdata,
    output logic [NREQ-1:0]     gnt,
    output logic [NREQ-1:0]     rvalid,
    output logic [NREQ*DW-1:0]  rdata,
    output logic                p0_en,
    output logic                p0_we,
    output logic [AW-1:0]       p0_addr,
    output logic [DW-1:0]       p0_wdata,
    output logic                p1_en,
    output logic                p1_we,
    output logic [AW-1:0]       p1_addr,
    output logic [DW-1:0]       p1_wdata,
    input  logic [DW-1:0]       p0_rdata,
    input  logic [DW-1:0]       p1_rdata
);

    logic [RR_W-1:0]           ptr;
    logic [NREQ-1:0][NREQ-1:0] conflict;
    logic [NREQ-1:0]           w1_oh, w2_oh;
    logic                      w1_vld, w2_vld;
    logic [RR_W-1:0]           w1_idx, w2_idx;
    port_tag_t                 tag0_p0, tag1_p0;
    port_tag_t                 tag0_p1, tag1_p1;
    logic [NREQ-1:0]           rvalid_p0;

    // A pair conflicts when it targets one word and at least one side writes.
    always_comb begin
        conflict = '0;
        for (int i = 0; i < NREQ; i++) begin
            for (int j = 0; j < NREQ; j++) begin
                conflict[i][j] = (addr[i*AW +: AW] == addr[j*AW +: AW]) && (we[i] || we[j]);
            end
        end
    end

    rr_pick2 #(
        .NREQ (NREQ),
        .W    (RR_W)
    ) u_pick (
        .req      (req),
        .ptr      (ptr),
        .conflict (conflict),
        .w1_oh    (w1_oh),
        .w2_oh    (w2_oh),
        .w1_vld   (w1_vld),
        .w2_vld   (w2_vld),
        .w1_idx   (w1_idx),
        .w2_idx   (w2_idx)
    );

    // Stage p0: grant and RAM port drive, all in the request cycle.
    always_comb begin
        gnt      = rst_n ? (w1_oh | w2_oh) : '0;
        p0_en    = rst_n & w1_vld;
        p1_en    = rst_n & w2_vld;
        p0_we    = p0_en & we[w1_idx];
        p1_we    = p1_en & we[w2_idx];
        p0_addr  = p0_en ? addr[w1_idx*AW +: AW]  : '0;
        p1_addr  = p1_en ? addr[w2_idx*AW +: AW]  : '0;
        p0_wdata = p0_en ? wdata[w1_idx*DW +: DW] : '0;
        p1_wdata = p1_en ? wdata[w2_idx*DW +: DW] : '0;

        tag0_p0.valid = p0_en & ~p0_we;
        tag0_p0.index = w1_idx;
        tag1_p0.valid = p1_en & ~p1_we;
        tag1_p0.index = w2_idx;

        rvalid_p0 = '0;
        if (tag0_p0.valid) rvalid_p0[tag0_p0.index] = 1'b1;
        if (tag1_p0.valid) rvalid_p0[tag1_p0.index] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr     <= '0;
            tag0_p1 <= '0;
            tag1_p1 <= '0;
            rvalid  <= '0;
        end else begin
            if (w1_vld) ptr <= (w2_vld ? w2_idx : w1_idx) + RR_W'(1);
            tag0_p1 <= tag0_p0;
            tag1_p1 <= tag1_p0;
            rvalid  <= rvalid_p0;
        end
    end

    // Stage p1: RAM read data returns, routed by the tag captured at grant.
    always_comb begin
        rdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (tag0_p1.valid && tag0_p1.index == RR_W'(i))
                rdata[i*DW +: DW] = p0_rdata;
            else if (tag1_p1.valid && tag1_p1.index == RR_W'(i))
                rdata[i*DW +: DW] = p1_rdata;
        end
    end

endmodule

// File: tb/tb_dpram_arbiter.sv
// Directed bench for dpram_arbiter with a behavioural dual-port RAM and a read scoreboard.
module tb_dpram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req, we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  gnt, rvalid;
    logic [31:0] rdata;
    logic        p0_en, p0_we, p1_en, p1_we;
    logic [3:0]  p0_addr, p1_addr;
    logic [7:0]  p0_wdata, p1_wdata;
    logic [7:0]  p0_rdata = 8'h00;
    logic [7:0]  p1_rdata = 8'h00;
    logic [7:0]  mem [16];

    typedef struct {
        int         idx;
        logic [7:0] data;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    dpram_arbiter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .we       (we),
        .addr     (addr),
        .wdata    (wdata),
        .gnt      (gnt),
        .rvalid   (rvalid),
        .rdata    (rdata),
        .p0_en    (p0_en),
        .p0_we    (p0_we),
        .p0_addr  (p0_addr),
        .p0_wdata (p0_wdata),
        .p1_en    (p1_en),
        .p1_we    (p1_we),
        .p1_addr  (p1_addr),
        .p1_wdata (p1_wdata),
        .p0_rdata (p0_rdata),
        .p1_rdata (p1_rdata)
    );

    // Dual-port RAM with one-cycle registered read.
    always @(posedge clk) begin
        if (p0_en) begin
            if (p0_we) mem[p0_addr] <= p0_wdata;
            else       p0_rdata     <= mem[p0_addr];
        end
        if (p1_en) begin
            if (p1_we) mem[p1_addr] <= p1_wdata;
            else       p1_rdata     <= mem[p1_addr];
        end
    end

    // Read-return monitor: pops one expectation per asserted rvalid lane.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rvalid[i]) begin
                n_cmp++;
                if (sbq.size() == 0) begin
                    n_err++;
                    $display("FAIL rvalid_unexpected lane %0d: got data %h, required no return", i, rdata[i*8 +: 8]);
                end else begin
                    mon_e = sbq.pop_front();
                    if (mon_e.idx != i || rdata[i*8 +: 8] !== mon_e.data) begin
                        n_err++;
                        $display("FAIL rdata lane %0d: got %h, required lane %0d data %h",
                                 i, rdata[i*8 +: 8], mon_e.idx, mon_e.data);
                    end
                end
            end else begin
                n_cmp++;
                if (rdata[i*8 +: 8] !== 8'h00) begin
                    n_err++;
                    $display("FAIL rdata_idle lane %0d: got %h, required 00", i, rdata[i*8 +: 8]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // One arbitration cycle: drive, check grant/ports at negedge, queue expected reads.
    task automatic cycle(input logic [3:0] r, input logic [3:0] w, input logic [15:0] a,
                         input logic [31:0] d, input logic [3:0] eg, input logic [3:0] ep0a,
                         input logic [3:0] ep1a, input logic [31:0] erd, input bit push);
        exp_t e;
        req   = r;
        we    = w;
        addr  = a;
        wdata = d;
        @(negedge clk);
        check("gnt",     32'(gnt),     32'(eg));
        check("p0_en",   32'(p0_en),   32'(eg != 4'd0));
        check("p1_en",   32'(p1_en),   32'($countones(eg) == 2));
        check("p0_addr", 32'(p0_addr), 32'(ep0a));
        check("p1_addr", 32'(p1_addr), 32'(ep1a));
        if (push) begin
            for (int i = 0; i < 4; i++) begin
                if (eg[i] && !w[i]) begin
                    e.idx  = i;
                    e.data = erd[i*8 +: 8];
                    sbq.push_back(e);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b1;
        req   = 4'b1111;
        we    = 4'b0000;
        addr  = 16'h0000;
        wdata = 32'h0;
        #1 rst_n = 1'b0;

        @(negedge clk);
        check("reset_gnt",    32'(gnt),    32'h0);
        check("reset_p0_en",  32'(p0_en),  32'h0);
        check("reset_p1_en",  32'(p1_en),  32'h0);
        check("reset_rvalid", 32'(rvalid), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Round-robin with writes to distinct words, ptr 0 -> 2 -> 0.
        cycle(4'b1111, 4'b1111, 16'hDCBA, 32'h23222120, 4'b0011, 4'hA, 4'hB, 32'h0, 1'b1);
        cycle(4'b1111, 4'b1111, 16'hDCBA, 32'h23222120, 4'b1100, 4'hC, 4'hD, 32'h0, 1'b1);
        cycle(4'b1111, 4'b1111, 16'hDCBA, 32'h23222120, 4'b0011, 4'hA, 4'hB, 32'h0, 1'b1);
        cycle(4'b1111, 4'b1111, 16'hDCBA, 32'h23222120, 4'b1100, 4'hC, 4'hD, 32'h0, 1'b1);
        // Load A5@5, 3C@3, 5A@9; park ptr back at 0.
        cycle(4'b0011, 4'b0011, 16'h0035, 32'h00003CA5, 4'b0011, 4'h5, 4'h3, 32'h0, 1'b1);
        cycle(4'b0100, 4'b0100, 16'h0900, 32'h005A0000, 4'b0100, 4'h9, 4'h0, 32'h0, 1'b1);
        cycle(4'b1000, 4'b1000, 16'hE000, 32'h33000000, 4'b1000, 4'hE, 4'h0, 32'h0, 1'b1);
        // Parallel reads on both ports.
        cycle(4'b0101, 4'b0000, 16'h0305, 32'h0,        4'b0101, 4'h5, 4'h3, 32'h003C00A5, 1'b1);
        cycle(4'b1000, 4'b1000, 16'hE000, 32'h44000000, 4'b1000, 4'hE, 4'h0, 32'h0, 1'b1);
        // Write/read conflict on word 7: only the write goes, then the read sees it.
        cycle(4'b0011, 4'b0001, 16'h0077, 32'h00000011, 4'b0001, 4'h7, 4'h0, 32'h0, 1'b1);
        cycle(4'b0010, 4'b0000, 16'h0070, 32'h0,        4'b0010, 4'h7, 4'h0, 32'h00001100, 1'b1);
        // Two reads of the same word are both granted.
        cycle(4'b1010, 4'b0000, 16'h9090, 32'h0,        4'b1010, 4'h9, 4'h9, 32'h5A005A00, 1'b1);
        cycle(4'b0001, 4'b0000, 16'h000A, 32'h0,        4'b0001, 4'hA, 4'h0, 32'h00000020, 1'b1);
        // No request: we/addr/wdata ignored.
        cycle(4'b0000, 4'b1111, 16'hFFFF, 32'hFFFFFFFF, 4'b0000, 4'h0, 4'h0, 32'h0, 1'b1);
        // Read in flight, then reset pulse: no return, ptr back to 0.
        cycle(4'b0100, 4'b0000, 16'h0500, 32'h0,        4'b0100, 4'h5, 4'h0, 32'h0, 1'b0);
        rst_n = 1'b0;
        req   = 4'b0000;
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("rvalid_after_reset", 32'(rvalid), 32'h0);
        @(posedge clk);
        #1;
        cycle(4'b1111, 4'b1111, 16'h4321, 32'h0,        4'b0011, 4'h1, 4'h2, 32'h0, 1'b1);
        cycle(4'b0000, 4'b0000, 16'h0000, 32'h0,        4'b0000, 4'h0, 4'h0, 32'h0, 1'b1);
        cycle(4'b0000, 4'b0000, 16'h0000, 32'h0,        4'b0000, 4'h0, 4'h0, 32'h0, 1'b1);

        check("scoreboard_drained", 32'(sbq.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
